// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: IF-stage PC register driven by the EX-stage PCSrc select.
// On an accepted redirect it loads the target on the next edge and raises
// flushD/flushE in the same cycle. It then ignores PCSrc for SHADOW_CYCLES
// cycles while the flushed bubbles drain.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   PCSrc           00 seq, 01 PCTarget, 10 ALUResult (jalr), 11 reserved (seq)
//   PCTarget        branch/jal target
//   ALUResult       jalr target (bit0 cleared on use)
//   stallF          hold PC when no redirect is taken
//   PC              registered fetch PC
//   PCPlus4         combinational PC+4 (wraps)
//   flushD, flushE  combinational flush requests for IF/ID and ID/EX
//   misaligned      registered 1-cycle pulse when an accepted target has bit1 set
//   redirect_count  accepted-redirect count
//
// Build option: define REDIRECT_CNT_EN to build the saturating redirect
// counter; otherwise redirect_count is tied to zero.
module pc_redirect_unit #(
  parameter int unsigned      WIDTH         = 32,
  parameter logic [WIDTH-1:0] RESET_PC      = '0,
  parameter int unsigned      SHADOW_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       PCSrc,
  input  logic [WIDTH-1:0] PCTarget,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic             stallF,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PCPlus4,
  output logic             flushD,
  output logic             flushE,
  output logic             misaligned,
  output logic [31:0]      redirect_count
);

  localparam int unsigned SHW = 2;

  typedef enum logic {
    RUN    = 1'b0,
    SHADOW = 1'b1
  } state_t;

  state_t           state;
  logic [SHW-1:0]   shadow_cnt;
  logic             is_redirect;
  logic             accept;
  logic [WIDTH-1:0] target;

  // Redirect decode; only RUN accepts, and reset suppresses the flush.
  always_comb begin
    is_redirect = (PCSrc == 2'b01) || (PCSrc == 2'b10);
    accept      = !rst && (state == RUN) && is_redirect;
    target      = (PCSrc == 2'b10) ? {ALUResult[WIDTH-1:1], 1'b0} : PCTarget;
  end

  assign PCPlus4 = PC + WIDTH'(4);
  assign flushD  = accept;
  assign flushE  = accept;

  // PC register and RUN/SHADOW control.
  always_ff @(posedge clk) begin
    if (rst) begin
      PC         <= RESET_PC;
      state      <= RUN;
      shadow_cnt <= '0;
      misaligned <= 1'b0;
    end else begin
      misaligned <= 1'b0;
      if (accept) begin
        // Redirect wins over stallF.
        PC         <= target;
        misaligned <= target[1];
        if (SHADOW_CYCLES != 0) begin
          state      <= SHADOW;
          shadow_cnt <= SHW'(SHADOW_CYCLES - 1);
        end
      end else begin
        if (!stallF) begin
          PC <= PCPlus4;
        end
        if (state == SHADOW) begin
          if (shadow_cnt == '0) begin
            state <= RUN;
          end else begin
            shadow_cnt <= shadow_cnt - SHW'(1);
          end
        end
      end
    end
  end

`ifdef REDIRECT_CNT_EN
  // Saturating count of accepted redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_count <= 32'h0;
    end else if (accept && (redirect_count != 32'hFFFF_FFFF)) begin
      redirect_count <= redirect_count + 32'd1;
    end
  end
`else
  assign redirect_count = 32'h0;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Bench for pc_redirect_unit: two instances (shadow 1 and shadow 3) share
// the stimulus; a cycle model checks both every cycle, and directed literal
// expectations pin the model.
module tb_pc_redirect_unit;

  localparam int unsigned SH_A = 1;
  localparam int unsigned SH_B = 3;
  localparam logic [31:0] RPC = 32'h100;
`ifdef REDIRECT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pcsrc;
  logic [31:0] pctarget;
  logic [31:0] alu;
  logic        stall;

  logic [31:0] pc_a, pc4_a, cnt_a, pc_b, pc4_b, cnt_b;
  logic        fd_a, fe_a, mis_a, fd_b, fe_b, mis_b;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  pc_redirect_unit #(.WIDTH(32), .RESET_PC(RPC), .SHADOW_CYCLES(SH_A)) u_a (
    .clk(clk), .rst(rst), .PCSrc(pcsrc), .PCTarget(pctarget), .ALUResult(alu),
    .stallF(stall), .PC(pc_a), .PCPlus4(pc4_a), .flushD(fd_a), .flushE(fe_a),
    .misaligned(mis_a), .redirect_count(cnt_a)
  );

  pc_redirect_unit #(.WIDTH(32), .RESET_PC(RPC), .SHADOW_CYCLES(SH_B)) u_b (
    .clk(clk), .rst(rst), .PCSrc(pcsrc), .PCTarget(pctarget), .ALUResult(alu),
    .stallF(stall), .PC(pc_b), .PCPlus4(pc4_b), .flushD(fd_b), .flushE(fe_b),
    .misaligned(mis_b), .redirect_count(cnt_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_ign = number of upcoming cycles in which PCSrc is still ignored.
  logic [31:0] m_pc  [2];
  int          m_ign [2];
  logic        m_mis [2];
  logic [31:0] m_cnt [2];
  bit          m_valid = 1'b0;

  function automatic bit wants_redirect(input logic [1:0] s);
    return (s == 2'd1) || (s == 2'd2);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_pc[k]  <= RPC;
        m_ign[k] <= 0;
        m_mis[k] <= 1'b0;
        m_cnt[k] <= 32'h0;
      end else if (m_ign[k] == 0 && wants_redirect(pcsrc)) begin
        m_pc[k]  <= (pcsrc == 2'd1) ? pctarget : (alu & 32'hFFFF_FFFE);
        m_mis[k] <= (pcsrc == 2'd1) ? pctarget[1] : alu[1];
        m_ign[k] <= (k == 0) ? int'(SH_A) : int'(SH_B);
        if (CNT_EN && m_cnt[k] != 32'hFFFF_FFFF) m_cnt[k] <= m_cnt[k] + 32'd1;
      end else begin
        m_mis[k] <= 1'b0;
        if (!stall) m_pc[k] <= m_pc[k] + 32'd4;
        if (m_ign[k] > 0) m_ign[k] <= m_ign[k] - 1;
      end
    end
    if (rst) m_valid <= 1'b1;
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("A.PC",      pc_a,  m_pc[0]);
      check("A.PCPlus4", pc4_a, m_pc[0] + 32'd4);
      check("A.flushD",  32'(fd_a), 32'(!rst && m_ign[0] == 0 && wants_redirect(pcsrc)));
      check("A.flushE",  32'(fe_a), 32'(!rst && m_ign[0] == 0 && wants_redirect(pcsrc)));
      check("A.misal",   32'(mis_a), 32'(m_mis[0]));
      check("A.count",   cnt_a, m_cnt[0]);
      check("B.PC",      pc_b,  m_pc[1]);
      check("B.PCPlus4", pc4_b, m_pc[1] + 32'd4);
      check("B.flushD",  32'(fd_b), 32'(!rst && m_ign[1] == 0 && wants_redirect(pcsrc)));
      check("B.flushE",  32'(fe_b), 32'(!rst && m_ign[1] == 0 && wants_redirect(pcsrc)));
      check("B.misal",   32'(mis_b), 32'(m_mis[1]));
      check("B.count",   cnt_b, m_cnt[1]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic r, input logic [1:0] s, input logic [31:0] t,
                       input logic [31:0] a, input logic st);
    rst = r; pcsrc = s; pctarget = t; alu = a; stall = st;
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    rst = 1'b1; pcsrc = 2'd0; pctarget = '0; alu = '0; stall = 1'b0;

    // T1 reset
    tick(2);
    check("T1.pc_rst",  pc_a, 32'h100);
    check("T1.fd_rst",  32'(fd_a), 32'h0);
    check("T1.fe_rst",  32'(fe_a), 32'h0);
    check("T1.cnt_rst", cnt_a, 32'h0);
    drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    tick(1); check("T1.pc_104", pc_a, 32'h104);
    tick(1); check("T1.pc_108", pc_a, 32'h108);

    // T2 branch: reach PC=0x10, then redirect and probe the shadow cycle
    drive(1'b0, 2'd1, 32'h4, 32'h0, 1'b0);
    tick(1); check("T2.pc_4", pc_a, 32'h4);
    drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    tick(3); check("T2.pc_10", pc_a, 32'h10);
    drive(1'b0, 2'd1, 32'h40, 32'h0, 1'b0);
    check("T2.fd", 32'(fd_a), 32'h1);
    check("T2.fe", 32'(fe_a), 32'h1);
    tick(1); check("T2.pc_40", pc_a, 32'h40);
    drive(1'b0, 2'd1, 32'h80, 32'h0, 1'b0);
    check("T2.fd_shadow", 32'(fd_a), 32'h0);
    tick(1); check("T2.pc_44", pc_a, 32'h44);
    drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    tick(2); check("T2.pc_4c", pc_b, 32'h4C);

    // T3 jalr
    drive(1'b0, 2'd2, 32'h0, 32'h203, 1'b0);
    tick(1);
    check("T3.pc_202", pc_a, 32'h202);
    check("T3.mis_1",  32'(mis_a), 32'h1);
    drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    tick(1);
    check("T3.pc_206", pc_a, 32'h206);
    check("T3.mis_0",  32'(mis_a), 32'h0);
    tick(2);
    drive(1'b0, 2'd2, 32'h0, 32'h201, 1'b0);
    tick(1);
    check("T3.pc_200",  pc_b, 32'h200);
    check("T3.mis_200", 32'(mis_b), 32'h0);
    drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    tick(3); check("T3.pc_20c", pc_a, 32'h20C);

    // T4 stall vs redirect
    drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
    tick(3); check("T4.pc_hold", pc_a, 32'h20C);
    drive(1'b0, 2'd1, 32'h300, 32'h0, 1'b1);
    check("T4.fd_stall", 32'(fd_a), 32'h1);
    check("T4.fe_stall", 32'(fe_b), 32'h1);
    tick(1); check("T4.pc_300", pc_a, 32'h300);
    drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    tick(3); check("T4.pc_30c", pc_b, 32'h30C);

    // T5 wrap and reserved encoding
    drive(1'b0, 2'd1, 32'hFFFF_FFF8, 32'h0, 1'b0);
    tick(1);
    drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    tick(1);
    check("T5.pc_fffc", pc_a, 32'hFFFF_FFFC);
    check("T5.pc4_wrap", pc4_a, 32'h0);
    tick(1); check("T5.pc_wrap", pc_a, 32'h0);
    tick(1);
    drive(1'b0, 2'd3, 32'h900, 32'h900, 1'b0);
    check("T5.fd_rsvd", 32'(fd_b), 32'h0);
    tick(1); check("T5.pc_rsvd", pc_b, 32'h8);

    // T6 reset in the 2nd shadow cycle of the shadow-3 instance
    drive(1'b0, 2'd1, 32'h500, 32'h0, 1'b0);
    tick(1);
    drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    tick(1);
    drive(1'b1, 2'd1, 32'h600, 32'h0, 1'b0);
    check("T6.fd_rst", 32'(fd_b), 32'h0);
    tick(1); check("T6.pc_rst", pc_b, 32'h100);
    drive(1'b0, 2'd1, 32'h700, 32'h0, 1'b0);
    check("T6.fd_after", 32'(fd_b), 32'h1);
    tick(1); check("T6.pc_700", pc_b, 32'h700);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
      tick(3);
      drive(1'b0, 2'd1, 32'h800 + 32'(i * 16), 32'h0, 1'b0);
      tick(1);
    end
    drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    tick(1);
    check("T6.cnt_b", cnt_b, CNT_EN ? 32'd5 : 32'd0);
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
